// File: rtl/peripheral_biu_pkg.sv
// Shared BIU encodings (size, burst, prot) and burst helper functions.
package peripheral_biu_pkg;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HWORD = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3,
    SIZE_QWORD = 3'd4
  } size_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } burst_e;

  localparam logic [2:0] PROT_DATA = 3'b001;
  localparam logic [2:0] PROT_PRIV = 3'b010;
  localparam logic [2:0] PROT_BUFF = 3'b100;

  localparam logic [2:0] SIZE_UNDEF = 3'b111;
  localparam logic [2:0] PROT_UNDEF = 3'b000;

  localparam int unsigned BOUNDARY_1K = 1024;
  localparam int unsigned BEATS_W     = 16;

  function automatic logic is_wrap(input logic [2:0] burst);
    return (burst == BURST_WRAP4) || (burst == BURST_WRAP8) || (burst == BURST_WRAP16);
  endfunction

  function automatic logic [BEATS_W-1:0] burst_beats(input logic [2:0] burst,
                                                     input logic [BEATS_W-1:0] len);
    logic [BEATS_W-1:0] beats;
    case (burst)
      BURST_SINGLE:             beats = BEATS_W'(1);
      BURST_INCR:               beats = len;
      BURST_WRAP4, BURST_INCR4: beats = BEATS_W'(4);
      BURST_WRAP8, BURST_INCR8: beats = BEATS_W'(8);
      default:                  beats = BEATS_W'(16);
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/peripheral_biu_addr_next.sv
// Combinational next-beat address: linear increment, or wrap within the burst block.
module peripheral_biu_addr_next #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [2:0]        burst_i,
  output logic [ADDR_W-1:0] addr_next_o
);
  import peripheral_biu_pkg::*;

  logic [ADDR_W-1:0]  step;
  logic [ADDR_W-1:0]  incr;
  logic [ADDR_W-1:0]  mask;
  logic [BEATS_W-1:0] beats;

  always_comb begin
    step  = ADDR_W'(1) << size_i;
    incr  = addr_i + step;
    beats = burst_beats(burst_i, BEATS_W'(1));
    // Wrap beat counts are powers of two, so blk-1 is a contiguous low mask.
    mask  = (ADDR_W'(beats) << size_i) - ADDR_W'(1);
    if (is_wrap(burst_i)) begin
      addr_next_o = (addr_i & ~mask) | (incr & mask);
    end else begin
      addr_next_o = incr;
    end
  end

endmodule

// File: rtl/peripheral_biu_burst_gen.sv
// Burst sequencer: validates one descriptor and expands it into per-beat requests.
module peripheral_biu_burst_gen #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [2:0]        req_size_i,
  input  logic [2:0]        req_burst_i,
  input  logic [2:0]        req_prot_i,
  input  logic              req_we_i,
  input  logic [LEN_W-1:0]  req_len_i,
  input  logic              abort_i,
  output logic              beat_valid_o,
  input  logic              beat_ready_i,
  output logic [ADDR_W-1:0] beat_addr_o,
  output logic [2:0]        beat_size_o,
  output logic [2:0]        beat_prot_o,
  output logic              beat_we_o,
  output logic              beat_first_o,
  output logic              beat_last_o,
  output logic [LEN_W-1:0]  beat_idx_o,
  output logic              done_o,
  output logic              err_o
);
  import peripheral_biu_pkg::*;

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, addr_nxt;
  logic [2:0]         size_q, size_d;
  logic [2:0]         burst_q, burst_d;
  logic [2:0]         prot_q, prot_d;
  logic               we_q, we_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   last_q, last_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [BEATS_W-1:0] req_beats;
  logic [6:0]         align_mask;
  logic [11:0]        span;
  logic               legal;
  logic               is_last;

  peripheral_biu_addr_next #(
    .ADDR_W(ADDR_W)
  ) u_addr_next (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .addr_next_o (addr_nxt)
  );

  always_comb begin
    req_beats  = burst_beats(req_burst_i, BEATS_W'(req_len_i));
    align_mask = 7'((8'd1 << req_size_i) - 8'd1);
    span       = 12'(req_beats << req_size_i) + {2'b00, req_addr_i[9:0]};
    legal      = 1'b1;
    if (req_size_i > MAX_SIZE) begin
      legal = 1'b0;
    end
    if ((req_addr_i[6:0] & align_mask) != '0) begin
      legal = 1'b0;
    end
    if ((req_burst_i == BURST_INCR) &&
        ((req_len_i == '0) || (req_len_i > LEN_W'(MAX_LEN)))) begin
      legal = 1'b0;
    end
    if (!is_wrap(req_burst_i) && (span > 12'(BOUNDARY_1K))) begin
      legal = 1'b0;
    end
  end

  assign is_last = (idx_q == last_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    burst_d = burst_q;
    prot_d  = prot_q;
    we_d    = we_q;
    idx_d   = idx_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (legal) begin
            addr_d  = req_addr_i;
            size_d  = req_size_i;
            burst_d = req_burst_i;
            prot_d  = req_prot_i;
            we_d    = req_we_i;
            idx_d   = '0;
            last_d  = LEN_W'(req_beats - BEATS_W'(1));
            state_d = ST_BURST;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        // A last-beat handshake wins over a simultaneous abort.
        if (beat_ready_i && is_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (abort_i) begin
          state_d = ST_IDLE;
        end else if (beat_ready_i) begin
          idx_d  = idx_q + LEN_W'(1);
          addr_d = addr_nxt;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      prot_q  <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      prot_q  <= prot_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign beat_valid_o = (state_q == ST_BURST);
  assign beat_first_o = beat_valid_o && (idx_q == '0);
  assign beat_last_o  = beat_valid_o && is_last;
  assign beat_addr_o  = addr_q;
  assign beat_size_o  = size_q;
  assign beat_prot_o  = prot_q;
  assign beat_we_o    = we_q;
  assign beat_idx_o   = idx_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_peripheral_biu_burst_gen.sv
// Bench for the BIU burst generator: address unit table, directed bursts, random descriptors.
module tb_peripheral_biu_burst_gen;
  import peripheral_biu_pkg::*;

  logic        clk_i;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [2:0]  req_size_i;
  logic [2:0]  req_burst_i;
  logic [2:0]  req_prot_i;
  logic        req_we_i;
  logic [4:0]  req_len_i;
  logic        abort_i;
  logic        beat_valid_o;
  logic        beat_ready_i;
  logic [31:0] beat_addr_o;
  logic [2:0]  beat_size_o;
  logic [2:0]  beat_prot_o;
  logic        beat_we_o;
  logic        beat_first_o;
  logic        beat_last_o;
  logic [4:0]  beat_idx_o;
  logic        done_o;
  logic        err_o;

  logic [31:0] an_addr;
  logic [2:0]  an_size;
  logic [2:0]  an_burst;
  logic [31:0] an_next;

  int n_pass  = 0;
  int n_total = 0;

  peripheral_biu_burst_gen #(
    .ADDR_W(32), .DATA_W(64), .MAX_LEN(16), .LEN_W(5)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_burst_i(req_burst_i),
    .req_prot_i(req_prot_i), .req_we_i(req_we_i), .req_len_i(req_len_i),
    .abort_i(abort_i),
    .beat_valid_o(beat_valid_o), .beat_ready_i(beat_ready_i),
    .beat_addr_o(beat_addr_o), .beat_size_o(beat_size_o), .beat_prot_o(beat_prot_o),
    .beat_we_o(beat_we_o), .beat_first_o(beat_first_o), .beat_last_o(beat_last_o),
    .beat_idx_o(beat_idx_o), .done_o(done_o), .err_o(err_o)
  );

  peripheral_biu_addr_next #(.ADDR_W(32)) u_an (
    .addr_i(an_addr), .size_i(an_size), .burst_i(an_burst), .addr_next_o(an_next)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: burst arithmetic straight from the rules, in plain integers.
  function automatic int unsigned m_beats(input int unsigned bu, input int unsigned len);
    case (bu)
      0: return 1;
      1: return len;
      2, 3: return 4;
      4, 5: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic bit m_wrap(input int unsigned bu);
    return (bu == 2) || (bu == 4) || (bu == 6);
  endfunction

  function automatic bit m_legal(input int unsigned a, input int unsigned sz,
                                 input int unsigned bu, input int unsigned len);
    int unsigned step;
    if (sz > 3) return 0;
    step = 1 << sz;
    if ((a % step) != 0) return 0;
    if (bu == 1 && (len == 0 || len > 16)) return 0;
    if (!m_wrap(bu) && ((a % 1024) + m_beats(bu, len) * step > 1024)) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] m_addr(input int unsigned a, input int unsigned sz,
                                         input int unsigned bu, input int unsigned i);
    int unsigned step, blk, base;
    step = 1 << sz;
    if (m_wrap(bu)) begin
      blk  = m_beats(bu, 0) * step;
      base = a - (a % blk);
      return base + ((a - base) + i * step) % blk;
    end
    return a + i * step;
  endfunction

  // mode: 0 ready held high, 1 ready toggles 1/0, 2 random ready
  task automatic do_burst(input int unsigned a, input int unsigned sz, input int unsigned bu,
                          input int unsigned pr, input int unsigned we, input int unsigned len,
                          input int mode, input int abort_at);
    bit legal, rdy, ab;
    int unsigned beats;
    int i, cyc;
    legal = m_legal(a, sz, bu, len);
    beats = m_beats(bu, len);
    chk("idle_ready", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_size_i  = 3'(sz);
    req_burst_i = 3'(bu);
    req_prot_i  = 3'(pr);
    req_we_i    = we[0];
    req_len_i   = 5'(len);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    if (!legal) begin
      chk("err_pulse", 32'(err_o), 32'd1);
      chk("err_no_beat", 32'(beat_valid_o), 32'd0);
      chk("err_ready", 32'(req_ready_o), 32'd1);
      @(posedge clk_i); #1;
      chk("err_single", 32'(err_o), 32'd0);
      chk("err_no_beat2", 32'(beat_valid_o), 32'd0);
      return;
    end
    chk("no_err", 32'(err_o), 32'd0);
    i = 0;
    cyc = 0;
    while (1) begin
      if (cyc > 200) begin
        n_total++;
        $display("FAIL burst_timeout: got beat %0d expected completion of %0d beats", i, beats);
        return;
      end
      chk("valid", 32'(beat_valid_o), 32'd1);
      chk("addr", beat_addr_o, m_addr(a, sz, bu, i));
      chk("idx", 32'(beat_idx_o), 32'(i));
      chk("first", 32'(beat_first_o), 32'(i == 0));
      chk("last", 32'(beat_last_o), 32'(i == int'(beats) - 1));
      chk("size", 32'(beat_size_o), sz);
      chk("prot", 32'(beat_prot_o), pr);
      chk("we", 32'(beat_we_o), we);
      chk("busy", 32'(req_ready_o), 32'd0);
      chk("no_done", 32'(done_o), 32'd0);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom % 3 != 0);
      ab  = (i == abort_at);
      beat_ready_i = rdy;
      abort_i      = ab;
      @(posedge clk_i); #1;
      beat_ready_i = 1'b0;
      abort_i      = 1'b0;
      cyc++;
      if (rdy && i == int'(beats) - 1) begin
        chk("done", 32'(done_o), 32'd1);
        chk("end_valid", 32'(beat_valid_o), 32'd0);
        chk("end_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk_i); #1;
        chk("done_single", 32'(done_o), 32'd0);
        return;
      end
      if (ab) begin
        chk("abort_valid", 32'(beat_valid_o), 32'd0);
        chk("abort_no_done", 32'(done_o), 32'd0);
        chk("abort_no_err", 32'(err_o), 32'd0);
        chk("abort_ready", 32'(req_ready_o), 32'd1);
        return;
      end
      if (rdy) i++;
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [2:0]  sz;
    logic [2:0]  bu;
    logic [31:0] exp;
  } an_vec_t;

  an_vec_t an_tab[11];

  initial begin
    an_tab[0]  = '{32'h0000_1004, SIZE_WORD,  BURST_INCR,   32'h0000_1008};
    an_tab[1]  = '{32'h0000_0038, SIZE_WORD,  BURST_WRAP4,  32'h0000_003C};
    an_tab[2]  = '{32'h0000_003C, SIZE_WORD,  BURST_WRAP4,  32'h0000_0030};
    an_tab[3]  = '{32'h0000_0034, SIZE_WORD,  BURST_WRAP4,  32'h0000_0038};
    an_tab[4]  = '{32'h0000_010E, SIZE_HWORD, BURST_INCR8,  32'h0000_0110};
    an_tab[5]  = '{32'hFFFF_FFFC, SIZE_WORD,  BURST_INCR,   32'h0000_0000};
    an_tab[6]  = '{32'h0000_007E, SIZE_HWORD, BURST_WRAP8,  32'h0000_0070};
    an_tab[7]  = '{32'h0000_00F8, SIZE_DWORD, BURST_WRAP16, 32'h0000_0080};
    an_tab[8]  = '{32'h0000_0010, SIZE_BYTE,  BURST_WRAP16, 32'h0000_0011};
    an_tab[9]  = '{32'h0000_001F, SIZE_BYTE,  BURST_WRAP16, 32'h0000_0010};
    an_tab[10] = '{32'h0000_0005, SIZE_BYTE,  BURST_SINGLE, 32'h0000_0006};

    rst_i = 1'b1;
    req_valid_i = 1'b0; req_addr_i = '0; req_size_i = '0; req_burst_i = '0;
    req_prot_i = '0; req_we_i = 1'b0; req_len_i = '0; abort_i = 1'b0; beat_ready_i = 1'b0;
    an_addr = '0; an_size = '0; an_burst = '0;

    for (int k = 0; k < 11; k++) begin
      an_addr  = an_tab[k].a;
      an_size  = an_tab[k].sz;
      an_burst = an_tab[k].bu;
      #1;
      chk($sformatf("addr_next[%0d]", k), an_next, an_tab[k].exp);
    end

    #1;
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_valid", 32'(beat_valid_o), 32'd0);
    chk("rst_addr", beat_addr_o, 32'd0);
    chk("rst_size", 32'(beat_size_o), 32'd0);
    chk("rst_prot", 32'(beat_prot_o), 32'd0);
    chk("rst_we", 32'(beat_we_o), 32'd0);
    chk("rst_idx", 32'(beat_idx_o), 32'd0);
    chk("rst_first", 32'(beat_first_o), 32'd0);
    chk("rst_last", 32'(beat_last_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;

    do_burst(32'h1004, 2, 0, 3, 1, 0, 0, -1);
    do_burst(32'h0038, 2, 2, 1, 0, 0, 0, -1);
    do_burst(32'h0100, 1, 5, 5, 1, 0, 1, -1);
    do_burst(32'h03F8, 2, 3, 0, 0, 0, 0, -1);
    do_burst(32'h1002, 2, 0, 0, 0, 0, 0, -1);
    do_burst(32'h0000, 2, 1, 0, 0, 0, 0, -1);
    do_burst(32'h0000, 4, 0, 0, 0, 0, 0, -1);
    do_burst(32'h03F0, 0, 1, 2, 1, 16, 0, -1);
    do_burst(32'h0000, 0, 1, 2, 1, 17, 0, -1);
    do_burst(32'h0000, 3, 7, 6, 0, 0, 0, 5);
    do_burst(32'h2000, 2, 0, 7, 1, 0, 0, -1);
    do_burst(32'h0040, 2, 3, 1, 0, 0, 0, 3);

    // Reset during beat 2 of an INCR4: burst dropped, no done afterwards.
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_addr_i = 32'h0200; req_size_i = 3'd2; req_burst_i = 3'd3;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    beat_ready_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("rst_mid_idx", 32'(beat_idx_o), 32'd2);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(beat_valid_o), 32'd0);
    chk("rst_mid_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    beat_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      chk("rst_mid_no_done", 32'(done_o), 32'd0);
      chk("rst_mid_idle", 32'(beat_valid_o), 32'd0);
    end

    for (int k = 0; k < 40; k++) begin
      int unsigned a, sz, bu, len;
      int ab_at;
      sz  = ($urandom % 8 == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      bu  = $urandom_range(0, 7);
      len = $urandom_range(0, 18);
      a   = $urandom_range(0, 32'h3FFF);
      if ($urandom % 4 != 0) a = a & ~((32'd1 << sz) - 1);
      ab_at = ($urandom % 5 == 0) ? int'($urandom_range(0, 15)) : -1;
      do_burst(a, sz, bu, $urandom_range(0, 7), $urandom_range(0, 1), len,
               int'($urandom_range(0, 2)), ab_at);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/peripheral_biu_burst_gen.md
Name: peripheral_biu_burst_gen

Overview:
Parametrised burst sequencer for the BIU. It accepts one burst descriptor (address, size, burst type, protection, direction, INCR length) and expands it into per-beat bus requests with a valid/ready handshake. It computes addresses for SINGLE, INCR, INCR4/8/16 and WRAP4/8/16. It rejects illegal descriptors: oversize, misaligned, bad length, or a 1 KB boundary crossing. It sits between the core-side memory request path and the AHB-Lite master port.

Parameters:
ADDR_W, 32, address width in bits (min 11)
DATA_W, 64, bus data width in bits; max legal size = log2(DATA_W/8)
MAX_LEN, 16, max beats for an INCR (undefined-length) burst
LEN_W, 5, width of req_len_i and beat_idx_o; must hold MAX_LEN

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_valid_i  in  1  descriptor valid
req_ready_o  out  1  generator idle; descriptor accepted when valid&&ready
req_addr_i  in  ADDR_W  start address
req_size_i  in  3  BYTE..QWORD encoding
req_burst_i  in  3  SINGLE..INCR16 encoding
req_prot_i  in  3  protection encoding, passed through
req_we_i  in  1  1=write
req_len_i  in  LEN_W  beat count, used only for INCR
abort_i  in  1  kill the burst in progress
beat_valid_o  out  1  beat request valid
beat_ready_i  in  1  bus accepts beat
beat_addr_o  out  ADDR_W  beat address
beat_size_o  out  3  registered size
beat_prot_o  out  3  registered prot
beat_we_o  out  1  registered direction
beat_first_o  out  1  current beat is beat 0
beat_last_o  out  1  current beat is final beat
beat_idx_o  out  LEN_W  beat index, 0-based
done_o  out  1  one-cycle pulse: last beat handshaken
err_o  out  1  one-cycle pulse: descriptor rejected

Behaviour:
- Reset (async, rst_i=1): state IDLE. All outputs 0 except req_ready_o=1. Registered addr/size/prot/we/idx=0. Reset mid-burst drops the burst without a done_o pulse.
- States: IDLE, BURST.
- IDLE: req_ready_o=1, beat_valid_o=0. On req_valid_i, validate combinationally:
  - size > log2(DATA_W/8) -> illegal
  - addr not aligned to 1<<size -> illegal
  - INCR with len==0 or len>MAX_LEN -> illegal
  - beats*(1<<size) + addr[9:0] > 1024 for SINGLE/INCR/INCRn -> illegal; compute in 12 bits; WRAPn never crosses
  - Beats: SINGLE=1, INCR=req_len_i, INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16.
  - Illegal: err_o=1 next cycle, stay IDLE, no beat issued.
  - Legal: register the descriptor and go to BURST next cycle with beat_valid_o=1 and idx=0.
- BURST: req_ready_o=0, beat_valid_o=1; outputs stable until beat_ready_i.
  - Handshake on a non-last beat: idx+1, next address.
  - Handshake on the last beat: done_o=1 next cycle, go IDLE.
  - beat_first_o = (idx==0); beat_last_o = (idx==beats-1).
- Next address, step = 1<<size:
  - INCR/INCRn/SINGLE: addr+step, ADDR_W modulo.
  - WRAPn: blk = beats*step; next = (addr & ~(blk-1)) | ((addr+step) & (blk-1)).
- abort_i in BURST: go IDLE next cycle, beat_valid_o=0, no done_o, no err_o.
  - abort_i with last-beat handshake in the same cycle: burst counts complete, done_o pulses.
  - abort_i in IDLE: ignored.
- Latency: descriptor accept to first beat_valid_o = 1 cycle. Back-to-back: a new descriptor can be accepted the cycle after done_o (one idle cycle between bursts).
- Throughput: 1 beat/cycle with beat_ready_i held high.
- req_prot_i, req_we_i and req_size_i are passed through unchanged on every beat.

Decomposition:
- The shared package peripheral_biu_pkg holds the size, burst and prot encodings plus UNDEF values.
- Add to the package:
  - function burst_beats(burst, len) returning the beat count.
  - constant BOUNDARY_1K = 1024.
- One combinational sub-module, peripheral_biu_addr_next(addr, size, burst), returning the next beat address; unit-tested alone.

Test Plan:
- SINGLE WORD at 0x1004, ready high -> one beat at 0x1004, first=last=1, done_o on the following cycle.
- WRAP4 WORD at 0x0038 -> beats 0x38, 0x3C, 0x30, 0x34; last=1 on 0x34; done_o once.
- INCR8 HWORD at 0x0100, beat_ready_i toggled 1/0 -> addresses 0x100..0x10E step 2; outputs stable while ready=0; idx 0..7.
- Each illegal descriptor -> err_o single pulse, beat_valid_o stays 0, req_ready_o stays 1:
  - INCR4 WORD at 0x3F8 (crosses 1 KB)
  - WORD at 0x1002 (misaligned)
  - INCR with len=0
- INCR16 DWORD at 0x0, abort_i at idx=5 -> beat_valid_o=0 next cycle, no done_o; a new SINGLE is accepted immediately after.
- Assert rst_i during beat 2 of INCR4 -> beat_valid_o=0 and req_ready_o=1 asynchronously; no done_o after release.
